// File: rtl/sdr_bit_shifter_if.sv
// -----------------------------------------------------------------------------
// sdr_bit_shifter_if
//   Groups the strobe, command, SDA and result signals that connect the SDR
//   bit shifter to its controller, the SCL generator and the SDA pad mux.
//   Clock and reset are kept out of the interface and stay plain ports.
//
// Signals (direction as seen by the shifter, i.e. the slave modport)
//   i_scl_pos_edge       in   1-cycle strobe, SCL rose
//   i_scl_neg_edge       in   1-cycle strobe, SCL fell
//   i_sdr_scl_gen_pp_od  in   1 push-pull, 0 open-drain
//   i_start              in   start one frame
//   i_mode               in   00 WR, 01 RD, 10 ADDR, 11 illegal
//   i_tx_byte            in   byte to send
//   i_abort              in   synchronous abort
//   i_sda                in   synchronized SDA pad input
//   o_sda, o_sda_oe      out  SDA value and output enable
//   o_busy               out  frame in progress
//   o_done               out  1-cycle pulse, results valid
//   o_rx_byte, o_rx_t    out  sampled byte and T-bit (RD)
//   o_nack               out  sampled ACK level (ADDR)
//   o_err                out  1-cycle pulse, start with illegal mode
// -----------------------------------------------------------------------------
interface sdr_bit_shifter_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              i_scl_pos_edge;
    logic              i_scl_neg_edge;
    logic              i_sdr_scl_gen_pp_od;
    logic              i_start;
    logic [1:0]        i_mode;
    logic [DATA_W-1:0] i_tx_byte;
    logic              i_abort;
    logic              i_sda;
    logic              o_sda;
    logic              o_sda_oe;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_rx_byte;
    logic              o_rx_t;
    logic              o_nack;
    logic              o_err;

    // Controller / bench side.
    modport master (
        output i_scl_pos_edge, i_scl_neg_edge, i_sdr_scl_gen_pp_od, i_start, i_mode,
               i_tx_byte, i_abort, i_sda,
        input  o_sda, o_sda_oe, o_busy, o_done, o_rx_byte, o_rx_t, o_nack, o_err
    );

    // Shifter side.
    modport slave (
        input  i_scl_pos_edge, i_scl_neg_edge, i_sdr_scl_gen_pp_od, i_start, i_mode,
               i_tx_byte, i_abort, i_sda,
        output o_sda, o_sda_oe, o_busy, o_done, o_rx_byte, o_rx_t, o_nack, o_err
    );
endinterface

// File: rtl/sdr_bit_shifter.sv
// -----------------------------------------------------------------------------
// sdr_bit_shifter
//   Bit-level SDR serializer/deserializer. Shifts DATA_W payload bits (MSB
//   first) plus a 9th bit (odd-parity T-bit for WR, ACK for ADDR, sampled
//   T-bit for RD) onto or off SDA. Bits are driven on SCL falling-edge strobes
//   and sampled on SCL rising-edge strobes from the SCL generator.
//
// Ports
//   i_sdr_ctrl_clk    system clock
//   i_sdr_ctrl_rst_n  asynchronous active-low reset
//   bus               sdr_bit_shifter_if.slave: strobes, command, SDA, results
//
// Frame: IDLE -> SHIFT (bits 0..DATA_W) -> HOLD (until next SCL fall) -> IDLE.
// All outputs are registered.
// -----------------------------------------------------------------------------
module sdr_bit_shifter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             i_sdr_ctrl_clk,
    input  logic             i_sdr_ctrl_rst_n,
    sdr_bit_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold
    } state_e;

    typedef enum logic [1:0] {
        ModeWr   = 2'b00,
        ModeRd   = 2'b01,
        ModeAddr = 2'b10,
        ModeIll  = 2'b11
    } mode_e;

    // Bit position of the 9th (T/ACK) bit.
    localparam logic [CNT_W-1:0]  LastBit = CNT_W'(DATA_W);
    localparam logic [DATA_W-1:0] MsbOne  = {1'b1, {(DATA_W-1){1'b0}}};

    state_e            state_q;
    mode_e             mode_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] tx_q;
    logic              sda_q;
    logic              oe_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] rx_byte_q;
    logic              rx_t_q;
    logic              nack_q;

    logic [DATA_W-1:0] sample_mask;

    // Selects the rx_byte bit for the position currently being sampled.
    assign sample_mask = MsbOne >> bit_cnt_q;

    // Returns {oe, sda} for bit position k of a frame.
    function automatic logic [1:0] drive_bit(input mode_e            mode,
                                             input logic [DATA_W-1:0] tx,
                                             input logic [CNT_W-1:0]  k,
                                             input logic              pp);
        logic              drive;
        logic              b;
        logic [DATA_W-1:0] shifted;
        drive   = 1'b0;
        b       = 1'b1;
        shifted = tx << k;
        if (k < LastBit) begin
            if (mode != ModeRd) begin
                drive = 1'b1;
                b     = shifted[DATA_W-1];
            end
        end else if (mode == ModeWr) begin
            drive = 1'b1;
            b     = ~^tx;
        end
        if (!drive) begin
            return 2'b01;
        end else if (pp) begin
            return {1'b1, b};
        end else begin
            // Open drain: only pull low, the pull-up supplies a 1.
            return {~b, 1'b0};
        end
    endfunction

    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            state_q   <= StIdle;
            mode_q    <= ModeWr;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            sda_q     <= 1'b1;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rx_byte_q <= '0;
            rx_t_q    <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.i_abort) begin
                // Results are deliberately left untouched.
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                sda_q     <= 1'b1;
                oe_q      <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.i_start) begin
                            if (mode_e'(bus.i_mode) == ModeIll) begin
                                err_q <= 1'b1;
                            end else begin
                                state_q   <= StShift;
                                mode_q    <= mode_e'(bus.i_mode);
                                tx_q      <= bus.i_tx_byte;
                                bit_cnt_q <= '0;
                                busy_q    <= 1'b1;
                                {oe_q, sda_q} <= drive_bit(mode_e'(bus.i_mode), bus.i_tx_byte,
                                                           '0, bus.i_sdr_scl_gen_pp_od);
                            end
                        end
                    end
                    StShift: begin
                        // A rising strobe wins over a coincident falling one.
                        if (bus.i_scl_pos_edge) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LastBit) begin
                                if (mode_q == ModeRd) begin
                                    rx_t_q <= bus.i_sda;
                                end
                                if (mode_q == ModeAddr) begin
                                    nack_q <= bus.i_sda;
                                end
                                state_q <= StHold;
                                done_q  <= 1'b1;
                            end else if (mode_q == ModeRd) begin
                                rx_byte_q <= bus.i_sda ? (rx_byte_q | sample_mask)
                                                       : (rx_byte_q & ~sample_mask);
                            end
                        end else if (bus.i_scl_neg_edge) begin
                            {oe_q, sda_q} <= drive_bit(mode_q, tx_q, bit_cnt_q,
                                                       bus.i_sdr_scl_gen_pp_od);
                        end
                    end
                    StHold: begin
                        // bit_cnt stays saturated at DATA_W+1 here.
                        if (bus.i_scl_neg_edge && !bus.i_scl_pos_edge) begin
                            state_q <= StIdle;
                            sda_q   <= 1'b1;
                            oe_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.o_sda     = sda_q;
    assign bus.o_sda_oe  = oe_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_err     = err_q;
    assign bus.o_rx_byte = rx_byte_q;
    assign bus.o_rx_t    = rx_t_q;
    assign bus.o_nack    = nack_q;

endmodule

// File: tb/tb_sdr_bit_shifter.sv
// -----------------------------------------------------------------------------
// tb_sdr_bit_shifter
//   Self-checking bench for sdr_bit_shifter: a table of hand-computed frames,
//   hand-written abort / illegal-mode / reset sequences, and random frames
//   checked against a vector-level reference model.
// -----------------------------------------------------------------------------
module tb_sdr_bit_shifter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    sdr_bit_shifter_if #(.DATA_W(8)) bus ();

    sdr_bit_shifter #(
        .DATA_W(8),
        .CNT_W (4)
    ) dut (
        .i_sdr_ctrl_clk  (clk),
        .i_sdr_ctrl_rst_n(rst_n),
        .bus             (bus)
    );

    // 9-bit vectors hold bit position k at index 8-k (k=0 first on the wire).
    typedef struct {
        logic [1:0] mode;
        logic       pp;
        logic [7:0] tx;
        logic [8:0] sda_in;
        logic [8:0] exp_sda;
        logic [8:0] exp_oe;
        logic [7:0] exp_rx;
        logic       exp_t;
        logic       exp_nack;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] prev_rx   = 8'h00;
    logic       prev_t    = 1'b0;
    logic       prev_nack = 1'b0;
    vec_t       tbl[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic p, input logic n);
        bus.i_scl_pos_edge = p;
        bus.i_scl_neg_edge = n;
        step();
        bus.i_scl_pos_edge = 1'b0;
        bus.i_scl_neg_edge = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic at(input logic [8:0] v, input int k);
        logic [8:0] s;
        s = v << k;
        return s[8];
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_sda"}, bus.o_sda, 1);
        chk({tag, "_oe"}, bus.o_sda_oe, 0);
        chk({tag, "_busy"}, bus.o_busy, 0);
        chk({tag, "_done"}, bus.o_done, 0);
        chk({tag, "_rx"}, bus.o_rx_byte, 0);
        chk({tag, "_t"}, bus.o_rx_t, 0);
        chk({tag, "_nack"}, bus.o_nack, 0);
        chk({tag, "_err"}, bus.o_err, 0);
    endtask

    // Reference model: intended wire levels are the byte followed by its odd
    // parity; the mode decides which positions are driven.
    function automatic vec_t model(input logic [1:0] mode, input logic pp,
                                   input logic [7:0] tx, input logic [8:0] sda_in);
        vec_t       v;
        logic [8:0] line;
        logic [8:0] drv;
        line = {tx, ~^tx};
        case (mode)
            2'b00:   drv = 9'h1FF;
            2'b10:   drv = 9'h1FE;
            default: drv = 9'h000;
        endcase
        v.mode     = mode;
        v.pp       = pp;
        v.tx       = tx;
        v.sda_in   = sda_in;
        v.exp_oe   = pp ? drv : (drv & ~line);
        v.exp_sda  = pp ? ((line & drv) | ~drv) : ~drv;
        v.exp_rx   = sda_in[8:1];
        v.exp_t    = sda_in[0];
        v.exp_nack = sda_in[0];
        return v;
    endfunction

    // Runs one full frame. poke: a start with illegal mode at bit 3 that must be
    // ignored. both: coincident strobes at bit 2, the falling one must be ignored.
    task automatic run_frame(input vec_t v, input logic poke, input logic both, input int gap);
        logic [7:0] erx;
        logic       et;
        logic       en;
        erx = (v.mode == 2'b01) ? v.exp_rx : prev_rx;
        et  = (v.mode == 2'b01) ? v.exp_t : prev_t;
        en  = (v.mode == 2'b10) ? v.exp_nack : prev_nack;
        bus.i_sdr_scl_gen_pp_od = v.pp;
        bus.i_mode    = v.mode;
        bus.i_tx_byte = v.tx;
        bus.i_start   = 1'b1;
        step();
        bus.i_start   = 1'b0;
        // The frame must use what was captured at start.
        bus.i_mode    = 2'b11;
        bus.i_tx_byte = ~v.tx;
        chk("busy_rise", bus.o_busy, 1);
        for (int k = 0; k < 9; k++) begin
            for (int g = 0; g < gap; g++) step();
            if (poke && k == 3) begin
                bus.i_start = 1'b1;
                step();
                bus.i_start = 1'b0;
                chk("busy_start_no_err", bus.o_err, 0);
            end
            bus.i_sda = at(v.sda_in, k);
            chk($sformatf("sda_k%0d", k), bus.o_sda, at(v.exp_sda, k));
            chk($sformatf("oe_k%0d", k), bus.o_sda_oe, at(v.exp_oe, k));
            if (k == 8) chk("done_early", bus.o_done, 0);
            strobe(1'b1, both && k == 2);
            if (k < 8) begin
                if (both && k == 2) begin
                    chk("both_sda_held", bus.o_sda, at(v.exp_sda, 2));
                    chk("both_oe_held", bus.o_sda_oe, at(v.exp_oe, 2));
                end
                for (int g = 0; g < gap; g++) step();
                strobe(1'b0, 1'b1);
            end
        end
        chk("done_pulse", bus.o_done, 1);
        chk("rx_byte", bus.o_rx_byte, erx);
        chk("rx_t", bus.o_rx_t, et);
        chk("nack", bus.o_nack, en);
        chk("busy_hold", bus.o_busy, 1);
        step();
        chk("done_one_cycle", bus.o_done, 0);
        chk("hold_sda", bus.o_sda, at(v.exp_sda, 8));
        chk("hold_oe", bus.o_sda_oe, at(v.exp_oe, 8));
        chk("hold_busy", bus.o_busy, 1);
        strobe(1'b0, 1'b1);
        chk("end_busy", bus.o_busy, 0);
        chk("end_oe", bus.o_sda_oe, 0);
        chk("end_sda", bus.o_sda, 1);
        chk("end_done", bus.o_done, 0);
        prev_rx   = erx;
        prev_t    = et;
        prev_nack = en;
    endtask

    initial begin
        //            mode   pp    tx     sda_in        exp_sda       exp_oe        rx     t     nack
        tbl[0] = '{2'b00, 1'b1, 8'hA5, 9'b000000000, 9'b101001011, 9'b111111111, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 1'b1, 8'h00, 9'b001111000, 9'b111111111, 9'b000000000, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{2'b10, 1'b0, 8'hFC, 9'b101010100, 9'b000000001, 9'b000000110, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{2'b10, 1'b0, 8'hFC, 9'b000000001, 9'b000000001, 9'b000000110, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{2'b00, 1'b0, 8'hA5, 9'b111111111, 9'b000000000, 9'b010110100, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{2'b01, 1'b0, 8'h00, 9'b100000011, 9'b111111111, 9'b000000000, 8'h81, 1'b1, 1'b0};
        tbl[6] = '{2'b00, 1'b1, 8'h07, 9'b000000000, 9'b000001110, 9'b111111111, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{2'b10, 1'b1, 8'h5A, 9'b000000001, 9'b010110101, 9'b111111110, 8'h00, 1'b0, 1'b1};
        tbl[8] = '{2'b00, 1'b0, 8'h00, 9'b000000000, 9'b000000000, 9'b111111110, 8'h00, 1'b0, 1'b0};

        bus.i_scl_pos_edge      = 1'b0;
        bus.i_scl_neg_edge      = 1'b0;
        bus.i_sdr_scl_gen_pp_od = 1'b1;
        bus.i_start             = 1'b0;
        bus.i_mode              = 2'b00;
        bus.i_tx_byte           = 8'h00;
        bus.i_abort             = 1'b0;
        bus.i_sda               = 1'b1;

        step();
        step();
        check_reset("rst");
        rst_n = 1'b1;
        step();
        check_reset("post_rst");

        // Table-driven frames; the first also exercises the ignored start and
        // coincident strobes.
        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i], i == 0, i == 0, 1 + (i % 3));
        end

        // Illegal mode start.
        bus.i_mode  = 2'b11;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("err_pulse", bus.o_err, 1);
        chk("err_busy", bus.o_busy, 0);
        step();
        chk("err_one_cycle", bus.o_err, 0);
        chk("err_busy2", bus.o_busy, 0);

        // Abort after the 4th rising strobe of WR 0xFF.
        bus.i_sdr_scl_gen_pp_od = 1'b1;
        bus.i_mode    = 2'b00;
        bus.i_tx_byte = 8'hFF;
        bus.i_start   = 1'b1;
        step();
        bus.i_start   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) strobe(1'b0, 1'b1);
            strobe(1'b1, 1'b0);
        end
        chk("pre_abort_oe", bus.o_sda_oe, 1);
        bus.i_abort = 1'b1;
        step();
        bus.i_abort = 1'b0;
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_oe", bus.o_sda_oe, 0);
        chk("abort_sda", bus.o_sda, 1);
        chk("abort_done", bus.o_done, 0);
        run_frame(tbl[0], 1'b0, 1'b0, 1);

        // Reset mid-RD frame, then a fresh RD 0x81.
        bus.i_mode  = 2'b01;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.i_sda = 1'b1;
            strobe(1'b1, 1'b0);
            strobe(1'b0, 1'b1);
        end
        chk("mid_rd_busy", bus.o_busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        step();
        rst_n = 1'b1;
        step();
        prev_rx   = 8'h00;
        prev_t    = 1'b0;
        prev_nack = 1'b0;
        run_frame(tbl[5], 1'b0, 1'b0, 2);

        // Random frames against the reference model.
        for (int n = 0; n < 40; n++) begin
            vec_t rv;
            rv = model(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                       8'($urandom), 9'($urandom));
            run_frame(rv, 1'b0, 1'b0, $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
